// File: rtl/toy_pack.sv
// Shared widths for the toy core's fetch path.
package toy_pack;

  localparam int ADDR_WIDTH      = 32;
  localparam int INST_WIDTH      = 32;
  localparam int WORD_BYTES_LOG2 = 2;

endpackage

// File: rtl/toy_fetch_rsp_fifo.sv
// Synchronous response FIFO with a single-cycle clear; push and pop may coincide when full.
module toy_fetch_rsp_fifo #(
  parameter int DEPTH     = 4,
  parameter int WIDTH     = 33,
  parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 push,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 pop,
  output logic [WIDTH-1:0]     rdata,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 empty,
  output logic                 full
);

  localparam int PTR_WIDTH = $clog2(DEPTH);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr_q;
  logic [PTR_WIDTH-1:0] rd_ptr_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 do_push;
  logic                 do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_WIDTH'(DEPTH));
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty & ~clear;
  assign do_push = push & (~full | do_pop) & ~clear;

  // NOTE: storage is not reset; only pointers and count need defined values.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_WIDTH'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_WIDTH'(1);
      count_q <= count_q + CNT_WIDTH'(do_push) - CNT_WIDTH'(do_pop);
    end
  end

endmodule

// File: rtl/toy_fetch_mem_bridge.sv
// Fetch-to-instruction-bus bridge: credit-limited in-order issue, buffered responses,
// and discard of stale in-flight responses after a redirect.
module toy_fetch_mem_bridge #(
  parameter int ADDR_WIDTH      = toy_pack::ADDR_WIDTH,
  parameter int DATA_WIDTH      = toy_pack::INST_WIDTH,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  flush,
  output logic                  ack_vld,
  input  logic                  ack_rdy,
  output logic [DATA_WIDTH-1:0] ack_data,
  output logic                  ack_err,
  output logic                  bus_req_vld,
  input  logic                  bus_req_rdy,
  output logic [ADDR_WIDTH-1:0] bus_req_addr,
  input  logic                  bus_rsp_vld,
  output logic                  bus_rsp_rdy,
  input  logic [DATA_WIDTH-1:0] bus_rsp_data,
  input  logic                  bus_rsp_err,
  output logic                  idle
);

  localparam int ALIGN = toy_pack::WORD_BYTES_LOG2;

  typedef struct packed {
    logic                  err;
    logic [DATA_WIDTH-1:0] data;
  } rsp_t;

  logic [CNT_WIDTH-1:0] inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;
  logic [CNT_WIDTH-1:0] fifo_cnt;
  logic [CNT_WIDTH:0]   credit_sum;
  logic                 credit_ok;
  logic                 issue;
  logic                 drop_rsp;
  logic                 rsp_push;
  logic                 rsp_pop;
  logic                 fifo_empty;
  logic                 fifo_full;
  rsp_t                 rsp_in;
  rsp_t                 rsp_head;

  // Every slot is either in flight or buffered, so a full FIFO alone exhausts credit.
  assign credit_sum   = {1'b0, inflight_q} + {1'b0, fifo_cnt};
  assign credit_ok    = ~fifo_full & (credit_sum < (CNT_WIDTH + 1)'(MAX_OUTSTANDING));
  assign bus_req_vld  = req_vld & credit_ok;
  assign req_rdy      = bus_req_rdy & credit_ok;
  assign bus_req_addr = {req_addr[ADDR_WIDTH-1:ALIGN], {ALIGN{1'b0}}};
  assign issue        = bus_req_vld & bus_req_rdy;
  assign bus_rsp_rdy  = 1'b1;

  assign drop_rsp    = bus_rsp_vld & (drop_q != '0);
  assign rsp_push    = bus_rsp_vld & ~drop_rsp;
  assign rsp_in.err  = bus_rsp_err;
  assign rsp_in.data = bus_rsp_data;

  // The head is hidden during a redirect so fetch never takes a word from the old stream.
  assign ack_vld  = ~fifo_empty & ~flush;
  assign rsp_pop  = ack_vld & ack_rdy;
  assign ack_data = rsp_head.data;
  assign ack_err  = rsp_head.err;
  assign idle     = (inflight_q == '0) & fifo_empty;

  // NOTE: defaults first so every path assigns and no latch is inferred.
  always_comb begin
    inflight_d = inflight_q;
    case ({issue, bus_rsp_vld})
      2'b10:   inflight_d = inflight_q + CNT_WIDTH'(1);
      2'b01:   inflight_d = inflight_q - CNT_WIDTH'(1);
      default: inflight_d = inflight_q;
    endcase

    drop_d = drop_q;
    if (flush)         drop_d = inflight_q - CNT_WIDTH'(bus_rsp_vld);
    else if (drop_rsp) drop_d = drop_q - CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  toy_fetch_rsp_fifo #(
    .DEPTH     (MAX_OUTSTANDING),
    .WIDTH     ($bits(rsp_t)),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (rsp_push),
    .wdata (rsp_in),
    .pop   (rsp_pop),
    .rdata (rsp_head),
    .count (fifo_cnt),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule

// File: tb/tb_toy_fetch_mem_bridge.sv
// Directed bench for toy_fetch_mem_bridge with a fixed-latency in-order bus model
// and an ack scoreboard of the words fetch is entitled to see.
module tb_toy_fetch_mem_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_vld, req_rdy;
  logic [AW-1:0] req_addr;
  logic          flush;
  logic          ack_vld, ack_rdy;
  logic [DW-1:0] ack_data;
  logic          ack_err;
  logic          bus_req_vld, bus_req_rdy;
  logic [AW-1:0] bus_req_addr;
  logic          bus_rsp_vld, bus_rsp_rdy;
  logic [DW-1:0] bus_rsp_data;
  logic          bus_rsp_err;
  logic          idle;

  toy_fetch_mem_bridge #(
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_vld      (req_vld),
    .req_rdy      (req_rdy),
    .req_addr     (req_addr),
    .flush        (flush),
    .ack_vld      (ack_vld),
    .ack_rdy      (ack_rdy),
    .ack_data     (ack_data),
    .ack_err      (ack_err),
    .bus_req_vld  (bus_req_vld),
    .bus_req_rdy  (bus_req_rdy),
    .bus_req_addr (bus_req_addr),
    .bus_rsp_vld  (bus_rsp_vld),
    .bus_rsp_rdy  (bus_rsp_rdy),
    .bus_rsp_data (bus_rsp_data),
    .bus_rsp_err  (bus_rsp_err),
    .idle         (idle)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; int due; } bus_txn_t;
  typedef struct { logic [AW-1:0] addr; logic err; } exp_t;

  bus_txn_t      bus_q[$];
  exp_t          exp_q[$];
  logic [DW-1:0] ack_data_log[$];
  logic          ack_err_log[$];

  int            n_checks = 0;
  int            n_pass = 0;
  int            cyc = 0;
  int            lat = 3;
  int            n_issue = 0;
  int            n_ack = 0;
  int            last_issue_cyc = 0;
  int            last_ack_cyc = 0;
  logic          saw_issue, saw_ack;
  logic [AW-1:0] err_addr = '1;
  logic [AW-1:0] stream_addr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  // One cycle: present the bus response, observe the settled cycle, advance to next negedge.
  task automatic step();
    exp_t e;
    bus_rsp_vld  = 1'b0;
    bus_rsp_data = '0;
    bus_rsp_err  = 1'b0;
    if (rst) begin
      bus_q.delete();
    end else if (bus_q.size() > 0 && bus_q[0].due == cyc) begin
      bus_rsp_vld  = 1'b1;
      bus_rsp_data = mem_word(bus_q[0].addr);
      bus_rsp_err  = (bus_q[0].addr == err_addr);
      bus_q.delete(0);
    end
    #1;
    saw_issue = !rst && bus_req_vld && bus_req_rdy;
    saw_ack   = !rst && ack_vld && ack_rdy;
    if (saw_issue) begin
      bus_q.push_back('{addr: bus_req_addr, due: cyc + lat});
      n_issue++;
      last_issue_cyc = cyc;
    end
    if (!rst && dut.u_fifo.push)
      check("fifo_no_overflow", dut.u_fifo.full & ~dut.u_fifo.pop, 1'b0);
    if (!rst && bus_rsp_vld)
      check("rsp_has_inflight", dut.inflight_q != '0, 1'b1);
    if (saw_ack) begin
      n_ack++;
      last_ack_cyc = cyc;
      ack_data_log.push_back(ack_data);
      ack_err_log.push_back(ack_err);
      check("ack_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ack_data", ack_data, mem_word(e.addr));
        check("ack_err", ack_err, e.err);
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drive_step();
    logic [AW-1:0] aligned;
    req_addr = stream_addr;
    aligned  = stream_addr & ~32'h3;
    step();
    if (saw_issue) begin
      exp_q.push_back('{addr: aligned, err: aligned == err_addr});
      stream_addr += 4;
    end
  endtask

  task automatic wait_ack(input string tag, input int bound);
    int n0 = n_ack;
    for (int i = 0; i < bound && n_ack == n0; i++) drive_step();
    check(tag, n_ack != n0, 1'b1);
  endtask

  task automatic wait_idle(input string tag, input int bound);
    for (int i = 0; i < bound && !idle; i++) drive_step();
    check(tag, idle, 1'b1);
  endtask

  task automatic issue_n(input int n, input int bound);
    int n0 = n_issue;
    req_vld = 1'b1;
    for (int i = 0; i < bound && n_issue - n0 < n; i++) drive_step();
    req_vld = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int t_iss, t_pop, first, n_iss0, n_ack0;
    rst = 1'b1; req_vld = 1'b0; req_addr = '0; flush = 1'b0; ack_rdy = 1'b0;
    bus_req_rdy = 1'b1; bus_rsp_vld = 1'b0; bus_rsp_data = '0; bus_rsp_err = 1'b0;
    stream_addr = '0;
    @(negedge clk);

    // Reset values; request path stays combinational even in reset.
    req_vld = 1'b1;
    req_addr = 32'h0000_1237;
    step();
    step();
    check("rst_ack_vld", ack_vld, 1'b0);
    check("rst_idle", idle, 1'b1);
    check("rst_bus_rsp_rdy", bus_rsp_rdy, 1'b1);
    check("rst_bus_req_vld", bus_req_vld, 1'b1);
    check("rst_req_rdy", req_rdy, 1'b1);
    check("rst_bus_req_addr", bus_req_addr, 32'h0000_1234);
    bus_req_rdy = 1'b0;
    #1;
    check("busy_bus_req_rdy", req_rdy, 1'b0);
    check("busy_bus_req_vld", bus_req_vld, 1'b1);
    bus_req_rdy = 1'b1;
    req_vld = 1'b0;
    @(negedge clk);
    cyc++;
    rst = 1'b0;

    // Single fetch, halfword-aligned address, latency 3.
    lat = 3; ack_rdy = 1'b1; req_vld = 1'b1;
    stream_addr = 32'h8000_0002;
    req_addr = stream_addr;
    #1;
    check("t1_bus_addr", bus_req_addr, 32'h8000_0000);
    ack_data_log.delete(); ack_err_log.delete();
    drive_step();
    check("t1_issued", saw_issue, 1'b1);
    t_iss = last_issue_cyc;
    req_vld = 1'b0;
    wait_ack("t1_ack_seen", 20);
    check("t1_latency", last_ack_cyc - t_iss, 4);
    check("t1_data", ack_data_log.size() > 0 ? ack_data_log[0] : '0, 32'hDA5A_C3C3);
    check("t1_err", ack_err_log.size() > 0 ? ack_err_log[0] : 1'b1, 1'b0);
    wait_idle("t1_idle", 10);

    // Streaming 16 words, latency 2.
    lat = 2; stream_addr = 32'h0000_1000;
    n_iss0 = n_issue; n_ack0 = n_ack; first = -1;
    for (int i = 0; i < 60 && n_ack - n_ack0 < 16; i++) begin
      req_vld = (n_issue - n_iss0) < 16;
      drive_step();
      if (saw_ack && first < 0) first = last_ack_cyc;
    end
    req_vld = 1'b0;
    check("t2_issues", n_issue - n_iss0, 16);
    check("t2_acks", n_ack - n_ack0, 16);
    check("t2_back_to_back", last_ack_cyc - first, 15);
    wait_idle("t2_idle", 10);

    // Backpressure: credits stop issue at 4, resume one cycle after the first pop.
    ack_rdy = 1'b0; req_vld = 1'b1; stream_addr = 32'h0000_2000;
    n_iss0 = n_issue; n_ack0 = n_ack;
    repeat (10) drive_step();
    check("t3_issued", n_issue - n_iss0, 4);
    check("t3_req_rdy_low", req_rdy, 1'b0);
    check("t3_ack_vld_held", ack_vld, 1'b1);
    ack_rdy = 1'b1;
    ack_data_log.delete();
    wait_ack("t3_first_pop", 5);
    t_pop = last_ack_cyc;
    t_iss = n_issue;
    for (int i = 0; i < 5 && n_issue == t_iss; i++) drive_step();
    check("t3_resume", last_issue_cyc - t_pop, 1);
    req_vld = 1'b0;
    wait_idle("t3_idle", 30);
    check("t3_all_acked", n_ack - n_ack0, n_issue - n_iss0);
    check("t3_word0", ack_data_log.size() > 0 ? ack_data_log[0] : '0, 32'h5A5A_E3C3);
    check("t3_word3", ack_data_log.size() > 3 ? ack_data_log[3] : '0, 32'h5A5A_E3CF);

    // Flush with 3 in flight; the new request is accepted in the flush cycle.
    lat = 4; stream_addr = 32'h0000_3000;
    n_iss0 = n_issue;
    issue_n(3, 10);
    check("t4_three_issued", n_issue - n_iss0, 3);
    exp_q.delete();
    flush = 1'b1; req_vld = 1'b1; stream_addr = 32'h8000_0100;
    drive_step();
    check("t4_flush_issue", saw_issue, 1'b1);
    flush = 1'b0; req_vld = 1'b0;
    ack_data_log.delete(); n_ack0 = n_ack;
    wait_idle("t4_idle", 30);
    check("t4_one_ack", n_ack - n_ack0, 1);
    check("t4_first_ack", ack_data_log.size() > 0 ? ack_data_log[0] : '0, 32'hDA5A_C2C3);

    // Flush coinciding with a response, then a second flush carrying a new request.
    lat = 3; stream_addr = 32'h0000_3100;
    issue_n(3, 10);
    exp_q.delete();
    flush = 1'b1;
    drive_step();
    exp_q.delete();
    req_vld = 1'b1; stream_addr = 32'h0000_4000;
    drive_step();
    check("t5_second_flush_issue", saw_issue, 1'b1);
    flush = 1'b0; req_vld = 1'b0;
    ack_data_log.delete(); n_ack0 = n_ack;
    wait_idle("t5_idle", 30);
    check("t5_one_ack", n_ack - n_ack0, 1);
    check("t5_first_ack", ack_data_log.size() > 0 ? ack_data_log[0] : '0, 32'h5A5A_83C3);

    // Bus error on the second response only.
    lat = 2; err_addr = 32'h0000_5004; stream_addr = 32'h0000_5000;
    ack_err_log.delete(); n_ack0 = n_ack;
    issue_n(3, 10);
    wait_idle("t6_idle", 20);
    check("t6_acks", n_ack - n_ack0, 3);
    check("t6_err0", ack_err_log.size() > 0 ? ack_err_log[0] : 1'b1, 1'b0);
    check("t6_err1", ack_err_log.size() > 1 ? ack_err_log[1] : 1'b0, 1'b1);
    check("t6_err2", ack_err_log.size() > 2 ? ack_err_log[2] : 1'b1, 1'b0);
    err_addr = '1;

    // Flush while words sit in the FIFO: ack is masked and the FIFO is cleared.
    ack_rdy = 1'b0; stream_addr = 32'h0000_6000;
    issue_n(2, 10);
    repeat (5) drive_step();
    check("t7_ack_ready", ack_vld, 1'b1);
    check("t7_head", ack_data, 32'h5A5A_A3C3);
    flush = 1'b1; ack_rdy = 1'b1; n_ack0 = n_ack;
    #1;
    check("t7_flush_masks_ack", ack_vld, 1'b0);
    exp_q.delete();
    drive_step();
    flush = 1'b0;
    check("t7_no_pop_in_flush", n_ack - n_ack0, 0);
    check("t7_cleared", ack_vld, 1'b0);
    check("t7_idle", idle, 1'b1);

    // Reset mid-operation returns to idle; the bus forgets its requests too.
    lat = 3; stream_addr = 32'h0000_7000;
    issue_n(2, 10);
    check("t8_busy", idle, 1'b0);
    rst = 1'b1;
    drive_step();
    rst = 1'b0;
    exp_q.delete();
    n_ack0 = n_ack;
    check("t8_rst_idle", idle, 1'b1);
    check("t8_rst_ack_vld", ack_vld, 1'b0);
    repeat (6) drive_step();
    check("t8_no_stale_ack", n_ack - n_ack0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
